// File: rtl/gpr_pkg.sv
// ============================================================================
//  Module   : gpr_pkg
//  Purpose  : Shared sizing constants and FSM state encodings for the
//             general-purpose register file and its dump sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpr_pkg;

    localparam int XLEN   = 64;
    localparam int NR_GPR = 32;
    localparam int GPR_AW = 5;

    typedef enum logic [0:0] {
        DBG_IDLE = 1'b0,
        DBG_RSP  = 1'b1
    } dbg_state_t;

    typedef enum logic [0:0] {
        DMP_IDLE = 1'b0,
        DMP_SEND = 1'b1
    } dmp_state_t;

endpackage

`default_nettype wire

// File: rtl/gpr_dump_seq.sv
// ============================================================================
//  Module   : gpr_dump_seq
//  Purpose  : Snapshot stream sequencer. Walks dump_idx from 0 to NR_GPR-1,
//             advancing on each valid&ready beat; stops after the last beat.
//  Config   : built only when GPR_DUMP_EN is defined.
//  Ports    : clk, rst (async, active-low)
//             i_start    - request a new dump (honoured only when idle)
//             i_ready    - downstream accepts the current beat
//             i_dbg_idle - debug FSM is idle (dump may start)
//             o_valid / o_last / o_busy / o_idx - stream control outputs
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef GPR_DUMP_EN
module gpr_dump_seq
    import gpr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_ready,
    input  logic              i_dbg_idle,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_busy,
    output logic [GPR_AW-1:0] o_idx
);

    localparam logic [GPR_AW-1:0] c_PENULT_IDX = GPR_AW'(NR_GPR - 2);

    dmp_state_t        r_state;
    logic [GPR_AW-1:0] r_idx;
    logic              r_valid;
    logic              r_last;

    // Outputs are registered alongside the state; r_last is precomputed
    // one beat ahead so it rises together with the final index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DMP_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                DMP_IDLE: begin
                    if (i_start && i_dbg_idle) begin
                        r_state <= DMP_SEND;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                    end
                end
                DMP_SEND: begin
                    if (i_ready) begin
                        if (r_last) begin
                            // Index is held at the final value; no wrap.
                            r_state <= DMP_IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_last <= (r_idx == c_PENULT_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= DMP_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_busy  = r_valid;
    assign o_last  = r_last;
    assign o_idx   = r_idx;

endmodule
`endif

`default_nettype wire

// File: rtl/gpr_file.sv
// ============================================================================
//  Module   : gpr_file
//  Purpose  : 32 x 64-bit register file (x0 hard-wired to zero) with two
//             bypassed combinational read ports, one core writeback port,
//             a valid/ready debug request/response channel and an optional
//             snapshot dump stream.
//  Config   : GPR_DUMP_EN - when defined, the dump stream is active; when
//             undefined, dump outputs are tied to zero and dump inputs ignored.
//  Ports    : clk, rst (async, active-low)
//             wb_en/wb_addr/wb_data        - core writeback
//             rs1_addr/rs1_data, rs2_*     - read ports
//             dbg_req_* / dbg_rsp_*        - debug channel
//             dump_*                       - snapshot stream
//             gpr_flat                     - all stored registers, x[i] at
//                                            bits [64*i+63:64*i]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpr_file
    import gpr_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_en,
    input  logic [GPR_AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    input  logic [GPR_AW-1:0]        rs1_addr,
    input  logic [GPR_AW-1:0]        rs2_addr,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    input  logic                     dbg_req_valid,
    output logic                     dbg_req_ready,
    input  logic                     dbg_req_wr,
    input  logic [GPR_AW-1:0]        dbg_req_addr,
    input  logic [XLEN-1:0]          dbg_req_wdata,
    output logic                     dbg_rsp_valid,
    input  logic                     dbg_rsp_ready,
    output logic [XLEN-1:0]          dbg_rsp_rdata,
    input  logic                     dump_start,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [GPR_AW-1:0]        dump_idx,
    output logic [XLEN-1:0]          dump_data,
    output logic                     dump_last,
    output logic                     dump_busy,
    output logic [NR_GPR*XLEN-1:0]   gpr_flat
);

    logic [XLEN-1:0] r_gpr [0:NR_GPR-1];   // entry 0 is never written
    dbg_state_t      r_dbg_state;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            w_dbg_hs;
    logic            w_dump_busy;

    // ------------------------------------------------------------------
    // Register array: core writeback and debug writes never coincide
    // because the debug port is only ready while wb_en is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_GPR; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            if (wb_en && (wb_addr != '0)) begin
                r_gpr[wb_addr] <= wb_data;
            end else if (w_dbg_hs && dbg_req_wr && (dbg_req_addr != '0)) begin
                r_gpr[dbg_req_addr] <= dbg_req_wdata;
            end
        end
    end

    // Read ports: x0 forced to zero, same-cycle writeback forwarded.
    always_comb begin
        rs1_data = r_gpr[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wb_en && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = r_gpr[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wb_en && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Debug FSM
    // ------------------------------------------------------------------
    assign dbg_req_ready = (r_dbg_state == DBG_IDLE) && !wb_en && !w_dump_busy;
    assign w_dbg_hs      = dbg_req_valid && dbg_req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dbg_state <= DBG_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_dbg_state)
                DBG_IDLE: begin
                    if (w_dbg_hs) begin
                        r_dbg_state <= DBG_RSP;
                        r_rsp_valid <= 1'b1;
                        if (dbg_req_wr) begin
                            r_rsp_rdata <= dbg_req_wdata;
                        end else if (dbg_req_addr == '0) begin
                            r_rsp_rdata <= '0;
                        end else begin
                            r_rsp_rdata <= r_gpr[dbg_req_addr];
                        end
                    end
                end
                DBG_RSP: begin
                    if (dbg_rsp_ready) begin
                        r_dbg_state <= DBG_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_dbg_state <= DBG_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_rsp_valid = r_rsp_valid;
    assign dbg_rsp_rdata = r_rsp_rdata;

    // ------------------------------------------------------------------
    // Snapshot dump stream
    // ------------------------------------------------------------------
`ifdef GPR_DUMP_EN
    logic w_dbg_idle;
    assign w_dbg_idle = (r_dbg_state == DBG_IDLE);

    gpr_dump_seq u_dump_seq (
        .clk        (clk),
        .rst        (rst),
        .i_start    (dump_start),
        .i_ready    (dump_ready),
        .i_dbg_idle (w_dbg_idle),
        .o_valid    (dump_valid),
        .o_last     (dump_last),
        .o_busy     (w_dump_busy),
        .o_idx      (dump_idx)
    );

    // Live stored value, so writebacks during a dump show in later beats.
    assign dump_data = (dump_idx == '0) ? '0 : r_gpr[dump_idx];
    assign dump_busy = w_dump_busy;
`else
    logic w_unused_dump;
    assign w_unused_dump = &{1'b0, dump_start, dump_ready};

    assign w_dump_busy = 1'b0;
    assign dump_valid  = 1'b0;
    assign dump_last   = 1'b0;
    assign dump_busy   = 1'b0;
    assign dump_idx    = '0;
    assign dump_data   = '0;
`endif

    // Stored values only (no writeback forwarding).
    generate
        for (genvar gi = 0; gi < NR_GPR; gi++) begin : g_flat
            if (gi == 0) begin : g_x0
                assign gpr_flat[gi*XLEN +: XLEN] = '0;
            end else begin : g_xn
                assign gpr_flat[gi*XLEN +: XLEN] = r_gpr[gi];
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 SHALL have no parameters; XLEN=64 and NR_GPR=32 come from gpr_pkg.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 wb_en / wb_addr / wb_data  in  1/5/64  core writeback port.
REQ-005 rs1_addr, rs2_addr  in  5  read addresses; rs1_data, rs2_data  out  64  read data.
REQ-006 dbg_req_valid  in  1; dbg_req_ready  out  1; dbg_req_wr  in  1; dbg_req_addr  in  5; dbg_req_wdata  in  64  debug request channel.
REQ-007 dbg_rsp_valid  out  1; dbg_rsp_ready  in  1; dbg_rsp_rdata  out  64  debug response channel.
REQ-008 dump_start  in  1; dump_valid  out  1; dump_ready  in  1; dump_idx  out  5; dump_data  out  64; dump_last  out  1; dump_busy  out  1  snapshot stream.
REQ-009 gpr_flat  out  2048  all registers, bits [64*i+63:64*i] = x[i], feeds the simulation observer.

Function
REQ-010 SHALL hold 32x64 registers; x0 reads 0 always; writes to x0 discarded.
REQ-011 rsN_data SHALL be combinational: 0 if addr 0; wb_data if wb_en and wb_addr==addr (bypass); else stored value.
REQ-012 wb_en=1 SHALL write wb_data to x[wb_addr] at the next edge; zero-cycle stall, always accepted.
REQ-013 Debug FSM states DBG_IDLE, DBG_RSP; reset state DBG_IDLE.
REQ-014 dbg_req_ready SHALL be 1 only in DBG_IDLE with wb_en=0 and dump_busy=0.
REQ-015 Request handshake (valid&ready) SHALL move to DBG_RSP; write: store wdata (x0 ignored), rsp_rdata=wdata; read: rsp_rdata=x[addr] sampled at handshake (0 for x0).
REQ-016 DBG_RSP SHALL drive dbg_rsp_valid=1 with stable rdata until dbg_rsp_ready, then return to DBG_IDLE; latency request-to-response exactly 1 cycle.
REQ-017 Dump FSM states DMP_IDLE, DMP_SEND; dump_start in DMP_IDLE with debug FSM in DBG_IDLE SHALL enter DMP_SEND with dump_idx=0; dump_start otherwise ignored.
REQ-018 DMP_SEND: dump_valid=1, dump_data=live x[dump_idx], dump_last=(dump_idx==31); idx increments on each dump_valid&dump_ready; beat with last returns to DMP_IDLE; idx does not wrap past 31.
REQ-019 dump_busy=1 exactly in DMP_SEND; core writebacks during a dump are still applied and appear in later beats.
REQ-020 gpr_flat SHALL reflect stored registers (no bypass), x0 slice 0.

Reset
REQ-021 While rst=0: all registers 0, both FSMs idle, dump_idx 0, dbg_rsp_valid/dump_valid/dump_last/dump_busy 0, rsp_rdata 0.
REQ-022 Reset asserted mid-transaction SHALL abort it immediately; no partial write committed after release.
REQ-023 Deassertion SHALL take effect on the first rising edge after release.

Configuration
REQ-024 GPR_DUMP_EN defined: dump port and FSM present per REQ-017..019.
REQ-025 GPR_DUMP_EN undefined: dump FSM absent; dump_valid, dump_last, dump_busy, dump_idx, dump_data tied 0; dump_start and dump_ready ignored; dbg_req_ready ignores dump_busy.

Structure
REQ-026 gpr_pkg SHALL hold XLEN, NR_GPR, GPR_AW=5, dbg_state_t and dmp_state_t enums.
REQ-027 Dump sequencer SHALL be sub-module gpr_dump_seq (FSM + index counter); array and debug FSM stay in gpr_file.

Verification
REQ-028 wb_en x5<=0x1234, same cycle rs1_addr=5 -> rs1_data=0x1234 (bypass); next cycle gpr_flat slice 5=0x1234.
REQ-029 Write x0<=0xFFFF via wb and via debug -> rs1_data(0)=0, gpr_flat[63:0]=0, debug response rdata=0xFFFF for write.
REQ-030 Debug read x7 (=0xABCD) with dbg_rsp_ready low 3 cycles -> rsp_valid held 4 cycles, rdata=0xABCD stable, req_ready=0 throughout.
REQ-031 dbg_req_valid with wb_en=1 -> req_ready=0 until wb_en drops; then accepted.
REQ-032 Dump with x[i]=i*0x10, dump_ready toggling, wb x31<=0x55 at beat 10 -> 32 beats idx 0..31, beat 31 data 0x55, dump_last only on idx 31.
REQ-033 rst low at dump beat 12 -> dump_valid=0, busy=0, all registers 0 same cycle; new dump_start after release restarts at idx 0.
